// File: rtl/stepper_phase_decoder.sv
// Full-step stepper phase decoder: step pulses, direction, signed position, step period, sticky jump flag.
// Optional glitch filter on the phase input is enabled by defining STEPPER_PHASE_FILTER_EN.
module stepper_phase_decoder #(
   parameter int POS_WIDTH     = 16,
   parameter int PERIOD_WIDTH  = 24,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              phase,
   input  logic                    clear,
   output logic                    step_pulse,
   output logic                    step_dir,
   output logic [POS_WIDTH-1:0]    position,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid,
   output logic                    phase_error
);

   typedef enum logic [0:0] {INIT = 1'b0, TRACK = 1'b1} state_t;

   localparam logic [POS_WIDTH-1:0]    POS_ONE    = POS_WIDTH'(1'b1);
   localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1'b1);
   localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = {PERIOD_WIDTH{1'b1}};

   if (FILTER_CYCLES < 1) begin : g_filter_cycles_invalid
      $error("FILTER_CYCLES must be at least 1");
   end

   // Forward order 00 -> 01 -> 11 -> 10 is a Gray sequence: next = {cur[0], ~cur[1]}.
   function automatic logic is_forward(input logic [1:0] from_ph, input logic [1:0] to_ph);
      return to_ph == {from_ph[0], ~from_ph[1]};
   endfunction

   logic [1:0] acc_phase_s;

`ifdef STEPPER_PHASE_FILTER_EN
   localparam int FCW = $clog2(FILTER_CYCLES + 1);
   localparam logic [FCW-1:0] FILT_LIMIT = FCW'(FILTER_CYCLES);
   localparam logic [FCW-1:0] FILT_ONE   = FCW'(1'b1);

   logic [1:0]     filt_r;
   logic [1:0]     cand_r;
   logic [FCW-1:0] run_r;
   logic           load_r;
   logic [FCW-1:0] run_s;

   // Length of the current run of identical raw samples, this sample included.
   always_comb begin
      run_s = FILT_ONE;
      if ((run_r != {FCW{1'b0}}) && (phase == cand_r)) begin
         run_s = run_r + FILT_ONE;
      end else begin
         run_s = FILT_ONE;
      end
   end

   // Until the first edge after reset the raw phase is taken as already settled.
   assign acc_phase_s = load_r ? phase : filt_r;

   // Glitch filter: a new value is accepted once it has been sampled FILTER_CYCLES times in a row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_r <= 2'b00;
         cand_r <= 2'b00;
         run_r  <= {FCW{1'b0}};
         load_r <= 1'b1;
      end else if (clear || load_r) begin
         filt_r <= phase;
         cand_r <= phase;
         run_r  <= {FCW{1'b0}};
         load_r <= 1'b0;
      end else if (phase == filt_r) begin
         run_r <= {FCW{1'b0}};
      end else if (run_s >= FILT_LIMIT) begin
         filt_r <= phase;
         run_r  <= {FCW{1'b0}};
      end else begin
         cand_r <= phase;
         run_r  <= run_s;
      end
   end
`else
   assign acc_phase_s = phase;
`endif

   state_t                  state_r;
   logic [1:0]              prev_phase_r;
   logic [PERIOD_WIDTH-1:0] period_cnt_r;
   logic                    seen_step_r;

   // Step decoder FSM; all outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= INIT;
         prev_phase_r <= 2'b00;
         period_cnt_r <= {PERIOD_WIDTH{1'b0}};
         seen_step_r  <= 1'b0;
         step_pulse   <= 1'b0;
         step_dir     <= 1'b0;
         position     <= {POS_WIDTH{1'b0}};
         period       <= {PERIOD_WIDTH{1'b0}};
         period_valid <= 1'b0;
         phase_error  <= 1'b0;
      end else if (clear) begin
         state_r      <= INIT;
         period_cnt_r <= {PERIOD_WIDTH{1'b0}};
         seen_step_r  <= 1'b0;
         step_pulse   <= 1'b0;
         position     <= {POS_WIDTH{1'b0}};
         period       <= {PERIOD_WIDTH{1'b0}};
         period_valid <= 1'b0;
         phase_error  <= 1'b0;
      end else begin
         case (state_r)
            INIT: begin
               prev_phase_r <= acc_phase_s;
               step_pulse   <= 1'b0;
               seen_step_r  <= 1'b0;
               state_r      <= TRACK;
            end
            TRACK: begin
               step_pulse   <= 1'b0;
               period_cnt_r <= (period_cnt_r == PERIOD_MAX) ? period_cnt_r : period_cnt_r + PERIOD_ONE;
               if (acc_phase_s != prev_phase_r) begin
                  prev_phase_r <= acc_phase_s;
                  if ((acc_phase_s ^ prev_phase_r) == 2'b11) begin
                     phase_error <= 1'b1;
                  end else begin
                     step_pulse   <= 1'b1;
                     step_dir     <= is_forward(prev_phase_r, acc_phase_s);
                     position     <= is_forward(prev_phase_r, acc_phase_s) ? position + POS_ONE
                                                                            : position - POS_ONE;
                     period_cnt_r <= PERIOD_ONE;
                     seen_step_r  <= 1'b1;
                     // The first step after INIT has no preceding step to measure against.
                     if (seen_step_r) begin
                        period       <= period_cnt_r;
                        period_valid <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_r    <= INIT;
               step_pulse <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed scenarios plus randomized phase traffic against a
// sequence-index reference model; a second instance uses POS_WIDTH=4, PERIOD_WIDTH=8.
module tb_stepper_phase_decoder;

   localparam int FC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  phase;
   logic        clear;
   logic        sp1, sd1, pv1, err1;
   logic [15:0] pos1;
   logic [23:0] per1;
   logic        sp2, sd2, pv2, err2;
   logic [3:0]  pos2;
   logic [7:0]  per2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stepper_phase_decoder #(.POS_WIDTH(16), .PERIOD_WIDTH(24), .FILTER_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .phase(phase), .clear(clear),
      .step_pulse(sp1), .step_dir(sd1), .position(pos1), .period(per1),
      .period_valid(pv1), .phase_error(err1));

   stepper_phase_decoder #(.POS_WIDTH(4), .PERIOD_WIDTH(8), .FILTER_CYCLES(FC)) dut_small (
      .clk(clk), .reset(reset), .phase(phase), .clear(clear),
      .step_pulse(sp2), .step_dir(sd2), .position(pos2), .period(per2),
      .period_valid(pv2), .phase_error(err2));

   // Reference model state: position as an unbounded integer, gaps in whole clock edges.
   logic       m_pulse, m_dir, m_valid, m_err, m_init, m_seen;
   logic [1:0] m_prev;
   int         m_pos;
   longint     m_gap, m_pgap;
`ifdef STEPPER_PHASE_FILTER_EN
   logic       m_load;
   logic [1:0] m_acc;
   logic [1:0] hist[$];
`endif

   function automatic int idx(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] nxt(input logic [1:0] p, input int d);
      logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      return seq[(idx(p) + d + 4) % 4];
   endfunction

   function automatic longint sat(input longint g, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (g > mx) ? mx : g;
   endfunction

   task automatic model_reset();
      m_pulse = 1'b0; m_dir = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_init = 1'b1; m_seen = 1'b0; m_prev = 2'b00;
      m_pos = 0; m_gap = 0; m_pgap = 0;
`ifdef STEPPER_PHASE_FILTER_EN
      m_load = 1'b1; m_acc = 2'b00; hist.delete();
`endif
   endtask

   // One clock edge: the model consumes the sampled inputs, then we move to the falling edge.
   task automatic tick();
      logic [1:0] s, d;
      logic       cl, same;
      int         diff;
      @(posedge clk);
      s = phase; cl = clear;
      if (!reset) begin
         model_reset();
      end else begin
`ifdef STEPPER_PHASE_FILTER_EN
         d = m_load ? s : m_acc;
         if (cl || m_load) begin
            m_acc = s; m_load = 1'b0; hist.delete();
         end else begin
            hist.push_back(s);
            if (hist.size() > FC) void'(hist.pop_front());
            same = (hist.size() == FC);
            foreach (hist[i]) if (hist[i] != s) same = 1'b0;
            if (same) m_acc = s;
         end
`else
         d = s; same = 1'b0;
`endif
         m_pulse = 1'b0;
         if (cl) begin
            m_pos = 0; m_gap = 0; m_pgap = 0; m_valid = 1'b0; m_err = 1'b0;
            m_init = 1'b1; m_seen = 1'b0;
         end else if (m_init) begin
            m_prev = d; m_init = 1'b0;
         end else if (d != m_prev) begin
            diff = (idx(d) - idx(m_prev) + 4) % 4;
            if (diff == 2) begin
               m_err = 1'b1; m_gap++;
            end else begin
               m_pulse = 1'b1;
               m_dir = (diff == 1);
               m_pos += (diff == 1) ? 1 : -1;
               if (m_seen) begin m_pgap = m_gap; m_valid = 1'b1; end
               m_seen = 1'b1; m_gap = 1;
            end
            m_prev = d;
         end else begin
            m_gap++;
         end
      end
      @(negedge clk);
   endtask

   task automatic hold(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         pulses += int'(sp1);
      end
   endtask

   task automatic restart_at(input logic [1:0] p);
      phase = p; clear = 1'b1; tick(); clear = 1'b0; tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; phase = 2'b11; clear = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if ({sp1, sd1, pos1, per1, pv1, err1} !== 45'd0) begin failures++;
         $display("FAIL reset_outputs got %h expected 0", {sp1, sd1, pos1, per1, pv1, err1}); end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if (sp1 !== 1'b0) begin failures++; $display("FAIL reset_hold_pulse cycle %0d got %b expected 0", i, sp1); end
      end
      checks++; if (pos1 !== 16'd0 || err1 !== 1'b0 || pv1 !== 1'b0) begin failures++;
         $display("FAIL reset_hold_state got pos=%h err=%b pv=%b expected 0 0 0", pos1, err1, pv1); end
   endtask

   task automatic test_forward();
      int p, total;
      logic [1:0] walk [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
      restart_at(2'b00);
      total = 0;
      for (int i = 0; i < 4; i++) begin
         phase = walk[i]; hold(10, p); total += p;
         if (i == 0) begin checks++; if (pv1 !== 1'b0) begin failures++; $display("FAIL fwd_valid_first got %b expected 0", pv1); end end
         if (i == 1) begin checks++; if (pv1 !== 1'b1) begin failures++; $display("FAIL fwd_valid_second got %b expected 1", pv1); end end
      end
      checks++; if (total !== 4) begin failures++; $display("FAIL fwd_pulses got %0d expected 4", total); end
      checks++; if (sd1 !== 1'b1 || pos1 !== 16'd4 || pos2 !== 4'd4) begin failures++;
         $display("FAIL fwd_pos got dir=%b pos=%h pos4=%h expected 1 0004 4", sd1, pos1, pos2); end
      checks++; if (per1 !== 24'd10 || per2 !== 8'd10 || pv1 !== 1'b1) begin failures++;
         $display("FAIL fwd_period got %0d/%0d pv=%b expected 10/10 1", per1, per2, pv1); end
   endtask

   task automatic test_reverse();
      int p, total;
      logic [1:0] walk [3] = '{2'b10, 2'b11, 2'b01};
      restart_at(2'b00);
      total = 0;
      for (int i = 0; i < 3; i++) begin phase = walk[i]; hold(10, p); total += p; end
      checks++; if (total !== 3) begin failures++; $display("FAIL rev_pulses got %0d expected 3", total); end
      checks++; if (sd1 !== 1'b0 || pos1 !== 16'hFFFD || pos2 !== 4'hD) begin failures++;
         $display("FAIL rev_pos got dir=%b pos=%h pos4=%h expected 0 fffd d", sd1, pos1, pos2); end
   endtask

   task automatic test_error_clear();
      int p;
      restart_at(2'b00);
      phase = 2'b11; hold(8, p);
      checks++; if (p !== 0 || err1 !== 1'b1 || pos1 !== 16'd0) begin failures++;
         $display("FAIL jump got pulses=%0d err=%b pos=%h expected 0 1 0000", p, err1, pos1); end
      phase = 2'b10; hold(8, p);
      checks++; if (p !== 1 || err1 !== 1'b1 || pos1 !== 16'd1 || sd1 !== 1'b1) begin failures++;
         $display("FAIL after_jump got pulses=%0d err=%b pos=%h dir=%b expected 1 1 0001 1", p, err1, pos1, sd1); end
      phase = 2'b00; clear = 1'b1; tick(); clear = 1'b0;
      checks++; if ({sp1, pos1, per1, pv1, err1} !== 43'd0 || sd1 !== 1'b1) begin failures++;
         $display("FAIL clear got pulse=%b pos=%h per=%h pv=%b err=%b dir=%b expected 0 0 0 0 0 1", sp1, pos1, per1, pv1, err1, sd1); end
      tick();
      phase = 2'b01; hold(8, p);
      checks++; if (p !== 1 || pos1 !== 16'd1 || pv1 !== 1'b0) begin failures++;
         $display("FAIL init_after_clear got pulses=%0d pos=%h pv=%b expected 1 0001 0", p, pos1, pv1); end
   endtask

   task automatic test_wrap_saturate();
      int p;
      restart_at(phase);
      for (int i = 0; i < 7; i++) begin phase = nxt(phase, 1); hold(6, p); end
      checks++; if (pos2 !== 4'd7) begin failures++; $display("FAIL wrap_pre got %h expected 7", pos2); end
      phase = nxt(phase, 1); hold(300, p);
      checks++; if (pos2 !== 4'h8 || pos1 !== 16'd8) begin failures++;
         $display("FAIL wrap got pos4=%h pos=%h expected 8 0008", pos2, pos1); end
      phase = nxt(phase, 1); hold(3, p);
      checks++; if (per2 !== 8'hFF || per1 !== 24'd300 || pv2 !== 1'b1) begin failures++;
         $display("FAIL saturate got per8=%h per24=%0d pv=%b expected ff 300 1", per2, per1, pv2); end
   endtask

   task automatic test_reset_mid_step();
      phase = nxt(phase, 1);
      #2 reset = 1'b0;
      #1;
      checks++; if (pos1 !== 16'd0 || per1 !== 24'd0 || pv1 !== 1'b0) begin failures++;
         $display("FAIL async_reset got pos=%h per=%h pv=%b expected 0 0 0", pos1, per1, pv1); end
      tick();
      checks++; if (sp1 !== 1'b0 || sd1 !== 1'b0 || pos1 !== 16'd0) begin failures++;
         $display("FAIL reset_mid_step got pulse=%b dir=%b pos=%h expected 0 0 0", sp1, sd1, pos1); end
      reset = 1'b1; tick(); tick();
   endtask

   task automatic test_random();
      int r, n;
      for (int it = 0; it < 500; it++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      phase = nxt(phase, 1);
         else if (r < 80) phase = nxt(phase, -1);
         else if (r < 88) phase = nxt(phase, 2);
         else if (r < 93) clear = 1'b1;
         n = ($urandom_range(0, 29) == 0) ? 280 : $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            tick();
            clear = 1'b0;
            checks++;
            if (sp1 !== m_pulse || sd1 !== m_dir || pos1 !== 16'(m_pos) || per1 !== 24'(sat(m_pgap, 24)) ||
                pv1 !== m_valid || err1 !== m_err) begin
               failures++;
               $display("FAIL random_w16 it=%0d got %b %b %h %h %b %b expected %b %b %h %h %b %b", it,
                        sp1, sd1, pos1, per1, pv1, err1, m_pulse, m_dir, 16'(m_pos), 24'(sat(m_pgap, 24)), m_valid, m_err);
            end
            checks++;
            if (sp2 !== m_pulse || sd2 !== m_dir || pos2 !== 4'(m_pos) || per2 !== 8'(sat(m_pgap, 8)) ||
                pv2 !== m_valid || err2 !== m_err) begin
               failures++;
               $display("FAIL random_w4 it=%0d got %b %b %h %h %b %b expected %b %b %h %h %b %b", it,
                        sp2, sd2, pos2, per2, pv2, err2, m_pulse, m_dir, 4'(m_pos), 8'(sat(m_pgap, 8)), m_valid, m_err);
            end
         end
      end
   endtask

`ifdef STEPPER_PHASE_FILTER_EN
   task automatic test_filter();
      int p, lat;
      restart_at(2'b00);
      hold(8, p);
      phase = 2'b01; hold(3, p);
      phase = 2'b00; hold(8, p);
      checks++; if (p !== 0 || err1 !== 1'b0 || pos1 !== 16'd0) begin failures++;
         $display("FAIL filter_glitch got pulses=%0d err=%b pos=%h expected 0 0 0000", p, err1, pos1); end
      phase = 2'b01; lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (sp1 === 1'b1 && lat == 0) lat = i;
      end
      checks++; if (lat !== FC + 1) begin failures++;
         $display("FAIL filter_latency got edge %0d expected %0d", lat, FC + 1); end
   endtask
`endif

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_error_clear();
      test_wrap_saturate();
      test_reset_mid_step();
      test_random();
`ifdef STEPPER_PHASE_FILTER_EN
      test_filter();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Consumes the 2-bit stepper coil phase after the two-flop synchroniser stage, i.e. already clean and clock-domain-safe.
- Decodes full-step sequence transitions into step pulses, direction, a signed position count and a step-period measurement.
- Flags illegal phase jumps.
- Sits between the input synchronisers and the analyser's capture/reporting logic.

Parameters:
- POS_WIDTH, 16: width of signed position counter (two's complement).
- PERIOD_WIDTH, 24: width of step-period counter, in clk cycles.
- FILTER_CYCLES, 4: stable-cycle count for the glitch filter (used only when the filter macro is defined); minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- phase  input  2  synchronised coil phase {B,A}.
- clear  input  1  synchronous clear of position, error and period state.
- step_pulse  output  1  one-cycle pulse per accepted step.
- step_dir  output  1  direction of last step: 1 = forward, 0 = reverse.
- position  output  POS_WIDTH  signed step count.
- period  output  PERIOD_WIDTH  cycles between last two steps.
- period_valid  output  1  period holds a real measurement.
- phase_error  output  1  sticky illegal-transition flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, port name reset, clock port clk. On reset low:
  - all outputs 0;
  - internal prev_phase 00, period counter 0;
  - FSM enters INIT.
- Forward sequence: 00 -> 01 -> 11 -> 10 -> 00. Reverse is the opposite order.
- FSM states:
  - INIT: on the first clk edge after reset release (or after clear), load prev_phase from the accepted phase. No step. Go to TRACK.
  - TRACK: compare the accepted phase with prev_phase every cycle.
- Transitions in TRACK:
  - Phase equal: nothing happens.
  - Single-bit forward change: step_pulse = 1 and step_dir = 1 on the next edge, position + 1.
  - Single-bit reverse change: step_pulse = 1, step_dir = 0, position - 1.
  - Two-bit change (00 <-> 11, 01 <-> 10): no pulse and no position change. phase_error set; step_dir unchanged.
  - In all three change cases, prev_phase updates to the new phase.
- Latency: step_pulse, position and step_dir update on the clk edge that samples the changed phase (one register stage, no extra delay). step_pulse is high for exactly one cycle.
- Position: wraps modulo 2^POS_WIDTH (0x7FFF + 1 -> 0x8000). No saturation.
- Period counter:
  - In TRACK, increments every cycle and saturates at all-ones.
  - On an accepted step, period is latched from the counter and the counter loads 1. Steps N cycles apart therefore give period = N.
  - The first step after INIT does not latch period and does not set period_valid.
  - Each later step latches period and sets period_valid.
  - A saturated counter latches as all-ones.
- phase_error is sticky until clear or reset.
- clear (synchronous, priority over a step in the same cycle):
  - position, period, period_valid, phase_error and the counter go to 0; step_pulse is 0;
  - FSM goes to INIT; step_dir holds.
- Reset mid-step: all state discarded immediately; no pulse is emitted.

Optional Feature:
- Macro STEPPER_PHASE_FILTER_EN.
- Defined: a glitch filter sits between phase and the decoder. A new phase value is accepted only after it has been constant for FILTER_CYCLES consecutive cycles, which adds FILTER_CYCLES cycles of latency. Shorter glitches are discarded: no step, no error. Reset and clear set the filtered phase to the current raw phase.
- Undefined: the accepted phase is the phase input directly; FILTER_CYCLES is ignored.

Test Plan:
- Reset release with phase = 11, then hold 20 cycles -> no step_pulse, position = 0, phase_error = 0.
- Forward walk 00,01,11,10,00, each held 10 cycles -> 4 pulses, step_dir = 1, position = 4, period = 10, period_valid high after the 2nd step.
- Reverse walk 00,10,11,01 from position 0 -> 3 pulses, step_dir = 0, position = 0xFFFD.
- Jump 00 -> 11 -> phase_error = 1, position unchanged. Then 11 -> 10 -> normal forward step, phase_error stays 1. Pulse clear -> all cleared, FSM in INIT.
- With POS_WIDTH = 4 at position = 7, one forward step -> position = 8 (wraps to -8). Hold with no step for more than 2^PERIOD_WIDTH cycles (PERIOD_WIDTH = 8) -> next step gives period = 0xFF.
- STEPPER_PHASE_FILTER_EN defined, FILTER_CYCLES = 4: a 3-cycle 00 -> 01 -> 00 glitch gives no pulse; a 01 held 4 cycles gives a pulse 4 cycles after the input change.
